// File: rtl/logic_unit_seq_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Purpose : shared definitions for the multi-cycle bitwise logic unit.
//           Holds the 2-bit operation codes and the controller state enum.
// Ports   : none (package).
// Config  : LOGIC_UNIT_PARITY_EN is consumed by the interface and the top,
//           not by this package.
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  // Operation codes. The 2-bit op field is fully decoded.
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit_seq_if.sv
// ---------------------------------------------------------------------------
// logic_unit_seq_if
// Purpose : request/result bundle between the ALU sequencer (master) and the
//           logic unit (slave).
// Signals : start  - operation request
//           op     - operation code (logic_unit_pkg OP_*)
//           x, y   - WIDTH-bit operands, sampled with start
//           busy   - operation in progress
//           done   - one-cycle pulse, result and flags valid
//           o      - WIDTH-bit result register
//           zero   - result is all zeros
//           parity - XOR-reduction of the result (LOGIC_UNIT_PARITY_EN only)
// Config  : LOGIC_UNIT_PARITY_EN adds the parity signal.
// ---------------------------------------------------------------------------
interface logic_unit_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] o;
  logic             zero;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             parity;
`endif

  // Sequencer side: issues requests, observes status and results.
  modport master (
    output start, op, x, y,
`ifdef LOGIC_UNIT_PARITY_EN
    input  parity,
`endif
    input  busy, done, o, zero
  );

  // Logic unit side.
  modport slave (
    input  start, op, x, y,
`ifdef LOGIC_UNIT_PARITY_EN
    output parity,
`endif
    output busy, done, o, zero
  );

endinterface

// File: rtl/logic_unit_seq_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
// Purpose : combinational SLICE-bit bitwise operator shared by every slice
//           of an operation.
// Ports   : i_a  - SLICE-bit operand A slice
//           i_b  - SLICE-bit operand B slice
//           i_op - operation code (logic_unit_pkg OP_*)
//           o_y  - SLICE-bit result slice
// Config  : none.
// ---------------------------------------------------------------------------
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [SLICE-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_XNOR: o_y = ~(i_a ^ i_b);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// ---------------------------------------------------------------------------
// logic_unit_seq
// Purpose : multi-cycle bitwise logic unit (AND/OR/XOR/XNOR) over WIDTH-bit
//           operands, SLICE bits per clock, N = WIDTH/SLICE cycles per
//           operation plus one DONE cycle.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - logic_unit_seq_if.slave (start/op/x/y in,
//                 busy/done/o/zero[/parity] out)
// Config  : LOGIC_UNIT_PARITY_EN enables the parity register and port.
// ---------------------------------------------------------------------------
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic            clk,
  input  logic            rst,
  logic_unit_seq_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [1:0]       r_op;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_o;
  logic             r_zero;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             r_parity;
`endif

  logic [SLICE-1:0] w_a;
  logic [SLICE-1:0] w_b;
  logic [SLICE-1:0] w_slice;
  logic [WIDTH-1:0] w_shadowNext;

  // Slice mux: select slice k of the latched operands for the shared operator.
  always_comb begin
    w_a = r_x[r_k*SLICE +: SLICE];
    w_b = r_y[r_k*SLICE +: SLICE];
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .i_a  (w_a),
    .i_b  (w_b),
    .i_op (r_op),
    .o_y  (w_slice)
  );

  // Shadow result with the current slice merged in. On the last RUN cycle
  // this is the complete result, which lets o and the flags be loaded on the
  // edge into DONE so they are already valid while done is high.
  always_comb begin
    w_shadowNext = r_shadow;
    w_shadowNext[r_k*SLICE +: SLICE] = w_slice;
  end

  // Next-state logic. start is only honoured in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = RUN;
      RUN:  if (r_k == K_LAST) w_next = DONE;
      DONE: w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus datapath. Reset takes priority over start and
  // aborts any operation in flight, clearing the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_op     <= OP_AND;
      r_k      <= '0;
      r_shadow <= '0;
      r_o      <= '0;
      r_zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_x      <= bus.x;
            r_y      <= bus.y;
            r_op     <= bus.op;
            r_k      <= '0;
            r_shadow <= '0;
          end
        end
        RUN: begin
          r_shadow <= w_shadowNext;
          r_k      <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_o    <= w_shadowNext;
            r_zero <= (w_shadowNext == '0);
`ifdef LOGIC_UNIT_PARITY_EN
            r_parity <= ^w_shadowNext;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.o    = r_o;
  assign bus.zero = r_zero;
`ifdef LOGIC_UNIT_PARITY_EN
  assign bus.parity = r_parity;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_seq
// Purpose : directed self-checking bench for logic_unit_seq with the default
//           WIDTH=16, SLICE=4 (N=4, latency 5).
// Config  : parity is only checked when LOGIC_UNIT_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_logic_unit_seq;
  import logic_unit_pkg::*;

  logic clk;
  logic rst;
  int   passCount;
  int   totalCount;

  logic_unit_seq_if #(.WIDTH(16)) busIf ();

  logic_unit_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 unit after
  // the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; returns just after edge E0.
  task automatic applyStimulus(input logic [1:0] opc, input logic [15:0] xv,
                               input logic [15:0] yv);
    busIf.op    = opc;
    busIf.x     = xv;
    busIf.y     = yv;
    busIf.start = 1'b1;
    stepCycle();
    busIf.start = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    busIf.start = 1'b0;
    busIf.op    = OP_AND;
    busIf.x     = '0;
    busIf.y     = '0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    totalCount++;
    if ({busIf.busy, busIf.done, busIf.zero} !== 3'b000)
      $display("[TB] FAIL reset_flags busy/done/zero got %b expected 000",
               {busIf.busy, busIf.done, busIf.zero});
    else passCount++;
    totalCount++;
    if (busIf.o !== 16'h0000)
      $display("[TB] FAIL reset_o got %h expected 0000", busIf.o);
    else passCount++;
`ifdef LOGIC_UNIT_PARITY_EN
    totalCount++;
    if (busIf.parity !== 1'b0)
      $display("[TB] FAIL reset_parity got %b expected 0", busIf.parity);
    else passCount++;
`endif
  endtask

  task automatic test_xor();
    int busyCycles;
    busyCycles = 0;
    applyStimulus(OP_XOR, 16'hFFFF, 16'h0F0F);
    for (int i = 1; i <= 4; i++) begin
      if (busIf.busy === 1'b1 && busIf.done === 1'b0) busyCycles++;
      stepCycle();
    end
    totalCount++;
    if (busyCycles !== 4)
      $display("[TB] FAIL xor_busy_cycles got %0d expected 4", busyCycles);
    else passCount++;
    totalCount++;
    if ({busIf.done, busIf.busy} !== 2'b10)
      $display("[TB] FAIL xor_done_cycle5 done/busy got %b expected 10",
               {busIf.done, busIf.busy});
    else passCount++;
    totalCount++;
    if (busIf.o !== 16'hF0F0 || busIf.zero !== 1'b0)
      $display("[TB] FAIL xor_result o=%h zero=%b expected F0F0 0",
               busIf.o, busIf.zero);
    else passCount++;
`ifdef LOGIC_UNIT_PARITY_EN
    totalCount++;
    if (busIf.parity !== 1'b0)
      $display("[TB] FAIL xor_parity got %b expected 0", busIf.parity);
    else passCount++;
`endif
    stepCycle();
    totalCount++;
    if (busIf.done !== 1'b0 || busIf.o !== 16'hF0F0)
      $display("[TB] FAIL xor_hold done=%b o=%h expected 0 F0F0",
               busIf.done, busIf.o);
    else passCount++;
  endtask

  task automatic test_and_input_change();
    applyStimulus(OP_AND, 16'hAAAA, 16'h5555);
    stepCycle();
    busIf.x = 16'hFFFF;
    busIf.y = 16'hFFFF;
    busIf.op = OP_OR;
    for (int i = 2; i <= 4; i++) stepCycle();
    totalCount++;
    if (busIf.done !== 1'b1 || busIf.o !== 16'h0000 || busIf.zero !== 1'b1)
      $display("[TB] FAIL and_result done=%b o=%h zero=%b expected 1 0000 1",
               busIf.done, busIf.o, busIf.zero);
    else passCount++;
    stepCycle();
  endtask

  task automatic test_back_to_back();
    applyStimulus(OP_OR, 16'h0001, 16'h0000);
    busIf.start = 1'b1;
    busIf.op    = OP_XNOR;
    busIf.x     = 16'h1234;
    busIf.y     = 16'h1234;
    for (int i = 1; i <= 4; i++) stepCycle();
    totalCount++;
    if (busIf.done !== 1'b1 || busIf.o !== 16'h0001 || busIf.zero !== 1'b0)
      $display("[TB] FAIL b2b_first done=%b o=%h zero=%b expected 1 0001 0",
               busIf.done, busIf.o, busIf.zero);
    else passCount++;
`ifdef LOGIC_UNIT_PARITY_EN
    totalCount++;
    if (busIf.parity !== 1'b1)
      $display("[TB] FAIL b2b_first_parity got %b expected 1", busIf.parity);
    else passCount++;
`endif
    stepCycle();
    busIf.start = 1'b0;
    totalCount++;
    if (busIf.busy !== 1'b1 || busIf.o !== 16'h0001)
      $display("[TB] FAIL b2b_restart busy=%b o=%h expected 1 0001",
               busIf.busy, busIf.o);
    else passCount++;
    for (int i = 2; i <= 4; i++) stepCycle();
    stepCycle();
    totalCount++;
    if (busIf.done !== 1'b1 || busIf.o !== 16'hFFFF || busIf.zero !== 1'b0)
      $display("[TB] FAIL b2b_second done=%b o=%h zero=%b expected 1 FFFF 0",
               busIf.done, busIf.o, busIf.zero);
    else passCount++;
`ifdef LOGIC_UNIT_PARITY_EN
    totalCount++;
    if (busIf.parity !== 1'b0)
      $display("[TB] FAIL b2b_second_parity got %b expected 0", busIf.parity);
    else passCount++;
`endif
    stepCycle();
  endtask

  task automatic test_start_during_run();
    int doneCount;
    doneCount = 0;
    applyStimulus(OP_XOR, 16'h1234, 16'h00FF);
    stepCycle();
    busIf.start = 1'b1;
    busIf.op    = OP_AND;
    busIf.x     = 16'h0000;
    stepCycle();
    busIf.start = 1'b0;
    if (busIf.done === 1'b1) doneCount++;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (busIf.done === 1'b1) doneCount++;
    end
    totalCount++;
    if (doneCount !== 1)
      $display("[TB] FAIL run_start_ignored done pulses got %0d expected 1",
               doneCount);
    else passCount++;
    totalCount++;
    if (busIf.o !== 16'h12CB || busIf.busy !== 1'b0)
      $display("[TB] FAIL run_start_result o=%h busy=%b expected 12CB 0",
               busIf.o, busIf.busy);
    else passCount++;
  endtask

  task automatic test_reset_abort();
    int doneCount;
    doneCount = 0;
    applyStimulus(OP_XOR, 16'hFFFF, 16'h0000);
    stepCycle();
    rst         = 1'b1;
    busIf.start = 1'b1;
    stepCycle();
    rst         = 1'b0;
    busIf.start = 1'b0;
    totalCount++;
    if (busIf.o !== 16'h0000 || busIf.busy !== 1'b0 || busIf.done !== 1'b0
        || busIf.zero !== 1'b0)
      $display("[TB] FAIL abort_state o=%h busy=%b done=%b zero=%b expected 0000 0 0 0",
               busIf.o, busIf.busy, busIf.done, busIf.zero);
    else passCount++;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      if (busIf.done === 1'b1 || busIf.busy === 1'b1) doneCount++;
    end
    totalCount++;
    if (doneCount !== 0)
      $display("[TB] FAIL abort_no_activity busy/done cycles got %0d expected 0",
               doneCount);
    else passCount++;
    applyStimulus(OP_AND, 16'hFF00, 16'h0FF0);
    for (int i = 1; i <= 4; i++) stepCycle();
    totalCount++;
    if (busIf.done !== 1'b1 || busIf.o !== 16'h0F00 || busIf.zero !== 1'b0)
      $display("[TB] FAIL abort_recover done=%b o=%h zero=%b expected 1 0F00 0",
               busIf.done, busIf.o, busIf.zero);
    else passCount++;
    stepCycle();
  endtask

  // Scenario sequence; ends with the summary line.
  initial begin
    passCount  = 0;
    totalCount = 0;
    test_reset();
    test_xor();
    test_and_input_change();
    test_back_to_back();
    test_start_during_run();
    test_reset_abort();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the integer ALU, the successor to the fixed 4-bit XOR gate. It computes AND/OR/XOR/XNOR over WIDTH-bit operands, processing SLICE bits per clock, with a start/busy/done handshake and zero/parity flags. It sits beside the adder in the ALU datapath and is driven by the ALU sequencer.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; N = WIDTH/SLICE cycles per operation.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR.
- x  in  WIDTH  operand A; sampled with start.
- y  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; o and the flags are valid.
- o  out  WIDTH  result register.
- zero  out  1  high when o == 0.
- parity  out  1  XOR-reduction of o; present only with LOGIC_UNIT_PARITY_EN.

## Operation
- One clock; reset is synchronous and active-high. Clock is `clk`; reset is `rst`.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch x, y and op into internal registers, clear the slice counter and shadow result, and go to RUN. Otherwise stay in IDLE.
- RUN: each cycle, apply op to slice k (bits k·SLICE+SLICE-1 : k·SLICE) of the latched operands. Write that slice into the shadow result and increment k.
  - When k == N-1, go to DONE.
- DONE: copy the shadow result to o, update zero and parity, and assert done for this cycle only.
  - If start=1 in DONE, latch new operands and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- o, zero and parity hold their values until the next DONE. Intermediate slices are never visible on o.
- start in RUN is ignored; no queueing.
- Input changes after the start cycle have no effect on the operation in flight.
- Reset values: state IDLE, busy 0, done 0, o 0, zero 0, parity 0, k 0.
- rst during RUN or DONE aborts the operation. No done pulse is produced and o is cleared to 0.
- Unused op codes do not exist (2-bit op is fully decoded).

## Timing
- start is sampled at edge E0.
- busy is high for cycles E0+1 through E0+N, and low in the DONE cycle.
- done is high for exactly one cycle, E0+N+1. o, zero and parity are valid from that cycle onward.
- Latency is N+1 cycles; with defaults, 5.
- Back-to-back throughput is one result per N+1 cycles.
- When rst and start are both high, rst wins.

## Configuration
- LOGIC_UNIT_PARITY_EN defined:
  - the parity port exists;
  - a parity register is updated in DONE as ^result and reset to 0.
- Not defined:
  - no parity port and no parity register;
  - all other behaviour is identical.

## Structure
- Package logic_unit_pkg contains:
  - op codes (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11);
  - the state enum (IDLE, RUN, DONE).
- Sub-module logic_slice is natural: combinational, SLICE-bit a/b/op in, SLICE-bit out. Instantiate it once and reuse it each cycle via the slice mux.
- The top holds the FSM, the slice counter (width $clog2(N), minimum 1), the operand/shadow registers and the flags.

## Test plan
Defaults WIDTH=16, SLICE=4.

- Reset, then idle 3 cycles -> busy=0, done=0, o=16'h0000, zero=0, parity=0.
- start, op=XOR, x=16'hFFFF, y=16'h0F0F -> busy high for 4 cycles; done at cycle 5; o=16'hF0F0, zero=0, parity=0.
- start, op=AND, x=16'hAAAA, y=16'h5555 -> o=16'h0000, zero=1. Inputs changed to x=16'hFFFF, y=16'hFFFF at E0+2 -> result unchanged.
- start, op=OR, x=16'h0001, y=16'h0000, then start=1 held through DONE with op=XNOR, x=16'h1234, y=16'h1234:
  - first done gives o=16'h0001, parity=1;
  - the next op starts from DONE; its done arrives 5 cycles later with o=16'hFFFF.
- start=1 pulsed during RUN -> ignored; exactly one done pulse.
- rst asserted at E0+2 of an XOR op -> no done pulse; o=0, busy=0 the cycle after; a new start then completes normally.
